regfile_writeback_ctrl: RTL and testbench

- Write-side front end of the 32x32 MIPS register file.
- Collects results from two producers, the single-cycle ALU and the multi-cycle load unit, in a small in-order FIFO.
- Drains one write per cycle onto the register file write port (address, data, write enable).
- Keeps a per-register pending scoreboard that the hazard unit reads to stall dependent instructions.

---
 rtl/regfile_wb_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/regfile_writeback_ctrl.sv | 174 +++++++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_pkg
//   Shared definitions for the register-file write-back front end.
//   REG_ADDR_W / NUM_REGS describe the 32x32 MIPS register file.
//   wb_entry_t is the canonical queued result {rd, data} at the default
//   32-bit data width; the FIFO stores the same layout as a flat vector so it
//   can follow the DATA_W parameter of the top level.
// ----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

    // Results targeting $0 are acknowledged but never written.
    function automatic logic is_reg_zero(input logic [REG_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
//   In-order synchronous FIFO with two push ports and one pop port.
//   When both pushes fire in the same cycle, push0 is stored ahead of push1.
//   A lone push1 takes the next free slot just like push0 would.
//   The caller guarantees there is room for the pushes (after the pop).
//
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     push0_i/din0_i  first (older) push
//     push1_i/din1_i  second (younger) push
//     pop_i           remove the head entry (only while non-empty)
//     head_o          head entry (content undefined when empty)
//     count_o         occupancy, 0..DEPTH
//     view_o          all slots, oldest first (only when WB_FORWARD_EN
//                     is defined; used by the forwarding search)
//
//   DEPTH must be a power of two, minimum 2, so pointers wrap naturally.
// ----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0_i,
    input  logic [WIDTH-1:0]         din0_i,
    input  logic                     push1_i,
    input  logic [WIDTH-1:0]         din1_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef WB_FORWARD_EN
    ,
    output logic [DEPTH*WIDTH-1:0]   view_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;

    // push1 lands right after push0 when both fire, otherwise at wptr.
    logic [PW-1:0]    wslot1;

    always_comb begin
        wslot1  = wptr_q + PW'(push0_i);
        wptr_d  = wptr_q + PW'(push0_i) + PW'(push1_i);
        rptr_d  = rptr_q + PW'(pop_i);
        count_d = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage holds no reset: stale slots are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push0_i) begin
            mem_q[wptr_q] <= din0_i;
        end
        if (push1_i) begin
            mem_q[wslot1] <= din1_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

`ifdef WB_FORWARD_EN
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            assign view_o[gi*WIDTH +: WIDTH] = mem_q[rptr_q + PW'(gi)];
        end
    endgenerate
`endif

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_writeback_ctrl
//   Write-side front end of the 32x32 MIPS register file. ALU and load
//   results are queued in order (load ahead of ALU when both arrive in the
//   same cycle) and drained one per cycle onto the register-file write port.
//   A per-register pending counter feeds the hazard unit via busy.
//
//   Ports:
//     clk, reset                    clock, asynchronous active-low reset
//     alu_valid/alu_rd/alu_data     ALU result, alu_ready = accepted
//     mem_valid/mem_rd/mem_data     load result, mem_ready = accepted
//     issue_valid/issue_rd          issued instruction with a destination
//     rf_we/rf_waddr/rf_wdata       register-file write port
//     busy[31:0]                    register r has writes pending
//     fifo_count                    queue occupancy, 0..DEPTH
//   Optional (macro WB_FORWARD_EN):
//     fwd_rd in, fwd_hit / fwd_data out: youngest queued value for fwd_rd.
// ----------------------------------------------------------------------------
module regfile_writeback_ctrl
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int PCNT_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [REG_ADDR_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  issue_rd,
    output logic                   rf_we,
    output logic [REG_ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [NUM_REGS-1:0]    busy,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0]  fwd_rd,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data
`endif
);

    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = REG_ADDR_W + DATA_W;

    // Same layout as wb_entry_t, sized by DATA_W.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } entry_t;

    entry_t        head;
    entry_t        mem_entry, alu_entry;
    logic [CW-1:0] count;
    logic [CW-1:0] space;
    logic          pop;
    logic          push_mem, push_alu;

    // ------------------------------------------------------------------
    // Accept / drain
    // ------------------------------------------------------------------
    assign pop = (count != '0);

    // The pop credit lets a full queue still accept one result per cycle.
    assign space     = CW'(DEPTH) - count + CW'(pop);
    assign mem_ready = (space >= CW'(1));
    // A load offered in the same cycle claims a slot first.
    assign alu_ready = mem_valid ? (space >= CW'(2)) : (space >= CW'(1));

    // $0 results are acknowledged but dropped.
    assign push_mem = mem_valid && mem_ready && !is_reg_zero(mem_rd);
    assign push_alu = alu_valid && alu_ready && !is_reg_zero(alu_rd);

    assign mem_entry = '{rd: mem_rd, data: mem_data};
    assign alu_entry = '{rd: alu_rd, data: alu_data};

`ifdef WB_FORWARD_EN
    logic [DEPTH*ENTRY_W-1:0] view;
`endif

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push0_i (push_mem),
        .din0_i  (mem_entry),
        .push1_i (push_alu),
        .din1_i  (alu_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
`ifdef WB_FORWARD_EN
        ,
        .view_o  (view)
`endif
    );

    assign rf_we      = pop;
    assign rf_waddr   = pop ? head.rd   : '0;
    assign rf_wdata   = pop ? head.data : '0;
    assign fifo_count = count;

    // ------------------------------------------------------------------
    // Pending scoreboard (no counter for $0, which is never busy)
    // ------------------------------------------------------------------
    localparam logic [PCNT_W-1:0] PMAX = {PCNT_W{1'b1}};

    assign busy[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_sb
            logic              inc, dec;
            logic [PCNT_W-1:0] pcnt_q, pcnt_d;

            assign inc = issue_valid && (issue_rd == REG_ADDR_W'(gi));
            assign dec = pop && (head.rd == REG_ADDR_W'(gi));

            // Saturate instead of wrapping; the assertions flag misuse.
            always_comb begin
                pcnt_d = pcnt_q;
                if (inc && !dec && pcnt_q != PMAX) begin
                    pcnt_d = pcnt_q + 1'b1;
                end else if (dec && !inc && pcnt_q != '0) begin
                    pcnt_d = pcnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_d;
                end
            end

            assign busy[gi] = (pcnt_q != '0);

            a_issue_overflow: assert property (
                @(posedge clk) disable iff (!reset) !(inc && pcnt_q == PMAX));
            a_pop_underflow: assert property (
                @(posedge clk) disable iff (!reset) !(dec && pcnt_q == '0));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Forwarding search: oldest to youngest so the last match wins.
    // ------------------------------------------------------------------
`ifdef WB_FORWARD_EN
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rd != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((CW'(k) < count) &&
                    (view[k*ENTRY_W + DATA_W +: REG_ADDR_W] == fwd_rd)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = view[k*ENTRY_W +: DATA_W];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback_ctrl
//   Directed table of per-cycle vectors (inputs plus the outputs expected
//   just before the next rising edge), followed by hand-written sequences for
//   asynchronous reset during a drain and, with WB_FORWARD_EN, forwarding.
// ----------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic [2:0]  fifo_count;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_rd;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    regfile_writeback_ctrl #(
        .DEPTH  (4),
        .DATA_W (32),
        .PCNT_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .fifo_count  (fifo_count)
`ifdef WB_FORWARD_EN
        ,
        .fwd_rd      (fwd_rd),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ird;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        e_mr;
        logic        e_ar;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [4:0] ird,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic e_mr, input logic e_ar, input logic e_we,
                       input logic [4:0] e_wa, input logic [31:0] e_wd,
                       input logic [2:0] e_cnt, input logic [31:0] e_busy);
        vec_t v;
        v = '{iv, ird, mv, mrd, md, av, ard, ad, e_mr, e_ar, e_we, e_wa, e_wd, e_cnt, e_busy};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
`ifdef WB_FORWARD_EN
        fwd_rd = '0;
`endif

        //   iv ird  mv mrd md            av ard ad            mr ar we wa wd            cnt busy
        // idle / reset state
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        // single ALU write to r8
        add(1, 8,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        add(0, 0,   0, 0, 0,             1, 8, 32'hAA,        1, 1, 0, 0, 0,            0, 32'h100);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 8, 32'hAA,       1, 32'h100);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        // simultaneous sources: load r5 before ALU r6
        add(1, 5,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        add(1, 6,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h20);
        add(0, 0,   1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, 1, 1, 0, 0, 0,            0, 32'h60);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 5, 32'h1111_1111, 2, 32'h60);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 6, 32'h2222_2222, 1, 32'h40);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        // $0 discard
        add(0, 0,   0, 0, 0,             1, 0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0,            0, 32'h0);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        // issue r1,r2,r3,r4,r7,r9,r10
        add(1, 1,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);
        add(1, 2,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h2);
        add(1, 3,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h6);
        add(1, 4,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'hE);
        add(1, 7,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h1E);
        add(1, 9,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h9E);
        add(1, 10,  0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h29E);
        // fill to full with continuous drain
        add(0, 0,   1, 1, 32'h101,       1, 2, 32'h202,       1, 1, 0, 0, 0,            0, 32'h69E);
        add(0, 0,   1, 3, 32'h303,       1, 4, 32'h404,       1, 1, 1, 1, 32'h101,      2, 32'h69E);
        add(0, 0,   1, 7, 32'h707,       1, 9, 32'h909,       1, 1, 1, 2, 32'h202,      3, 32'h69C);
        // full: only one slot via the pop credit, the load takes it
        add(0, 0,   1, 10, 32'hA0A,      1, 11, 32'hB0B,      1, 0, 1, 3, 32'h303,      4, 32'h698);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 4, 32'h404,      4, 32'h690);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 7, 32'h707,      3, 32'h680);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 9, 32'h909,      2, 32'h600);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 1, 10, 32'hA0A,     1, 32'h400);
        add(0, 0,   0, 0, 0,             0, 0, 0,             1, 1, 0, 0, 0,            0, 32'h0);

        // reset state while reset is held
        #3;
        chk("reset rf_we", 32'(rf_we), 32'h0);
        chk("reset fifo_count", 32'(fifo_count), 32'h0);
        chk("reset busy", busy, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            issue_valid = vecs[i].iv;  issue_rd = vecs[i].ird;
            mem_valid   = vecs[i].mv;  mem_rd   = vecs[i].mrd; mem_data = vecs[i].md;
            alu_valid   = vecs[i].av;  alu_rd   = vecs[i].ard; alu_data = vecs[i].ad;
            #1;
            chk($sformatf("v%0d mem_ready", i),  32'(mem_ready),  32'(vecs[i].e_mr));
            chk($sformatf("v%0d alu_ready", i),  32'(alu_ready),  32'(vecs[i].e_ar));
            chk($sformatf("v%0d rf_we", i),      32'(rf_we),      32'(vecs[i].e_we));
            chk($sformatf("v%0d rf_waddr", i),   32'(rf_waddr),   32'(vecs[i].e_wa));
            chk($sformatf("v%0d rf_wdata", i),   rf_wdata,        vecs[i].e_wd);
            chk($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d busy", i),       busy,            vecs[i].e_busy);
            $display("vec %0d: we=%0d waddr=%0d wdata=%08h cnt=%0d busy=%08h",
                     i, rf_we, rf_waddr, rf_wdata, fifo_count, busy);
            tick();
        end
        idle_inputs();

        // reset mid-drain: three entries left queued, then async reset
        issue_valid = 1'b1;
        issue_rd = 5'd12; tick();
        issue_rd = 5'd13; tick();
        issue_rd = 5'd14; tick();
        issue_rd = 5'd15; tick();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC;
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD;
        tick();
        mem_rd = 5'd14; mem_data = 32'hE;
        alu_rd = 5'd15; alu_data = 32'hF;
        tick();
        idle_inputs();
        chk("pre-reset fifo_count", 32'(fifo_count), 32'd3);
        chk("pre-reset busy", busy, 32'h0000_E000);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset rf_we", 32'(rf_we), 32'h0);
        chk("async reset fifo_count", 32'(fifo_count), 32'h0);
        chk("async reset busy", busy, 32'h0);
        $display("reset mid-drain: we=%0d cnt=%0d busy=%08h", rf_we, fifo_count, busy);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post-reset c%0d rf_we", c), 32'(rf_we), 32'h0);
            chk($sformatf("post-reset c%0d fifo_count", c), 32'(fifo_count), 32'h0);
        end

`ifdef WB_FORWARD_EN
        // forwarding: two writes to r9 queued, youngest value wins
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        tick();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'd1;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'd2;
        tick();
        idle_inputs();
        fwd_rd = 5'd9;
        #1;
        chk("fwd r9 hit", 32'(fwd_hit), 32'h1);
        chk("fwd r9 data", fwd_data, 32'd2);
        chk("fwd head data", rf_wdata, 32'd1);
        fwd_rd = 5'd5;
        #1;
        chk("fwd r5 hit", 32'(fwd_hit), 32'h0);
        chk("fwd r5 data", fwd_data, 32'd0);
        fwd_rd = 5'd0;
        #1;
        chk("fwd r0 hit", 32'(fwd_hit), 32'h0);
        $display("forward: hit=%0d data=%08h", fwd_hit, fwd_data);
        tick();
        tick();
        fwd_rd = 5'd9;
        #1;
        chk("fwd empty hit", 32'(fwd_hit), 32'h0);
        chk("fwd drained busy", busy, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
